// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, stop bits.
// Build option: define UART_TX_PARITY_EN to insert the parity bit (PARITY_ODD selects its sense).
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int MAX_BITS = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_serializer: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_serializer: STOP_BITS must be in 1..2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
      $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_step(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction

  logic par_r;
  logic par_s;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t               state_r;
  state_t               state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_s;
  logic                 tx_r;
  logic                 tx_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 done_r;
  logic                 done_s;

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      shift_r <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
`ifdef UART_TX_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  // Next-state and next-output decode; tx_s is the line level for the coming cycle.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    shift_s = shift_r;
    tx_s    = tx_r;
    done_s  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_s   = par_r;
`endif
    case (state_r)
      ST_IDLE: begin
        tx_s = 1'b1;
        // A tick arriving with the request is deliberately ignored.
        if (tx_start) begin
          state_s = ST_START;
          shift_s = tx_data;
          cnt_s   = '0;
          tx_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_s   = (PARITY_ODD != 0);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          state_s = ST_DATA;
          tx_s    = shift_r[0];
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
`ifdef UART_TX_PARITY_EN
          par_s   = parity_step(par_r, shift_r[0]);
`endif
          if (cnt_r == LAST_DATA) begin
            cnt_s = '0;
`ifdef UART_TX_PARITY_EN
            state_s = ST_PARITY;
            tx_s    = parity_step(par_r, shift_r[0]);
`else
            state_s = ST_STOP;
            tx_s    = 1'b1;
`endif
          end else begin
            cnt_s = cnt_r + CNT_ONE;
            tx_s  = shift_r[1];
          end
        end else begin
          state_s = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_tick) begin
          state_s = ST_STOP;
          cnt_s   = '0;
          tx_s    = 1'b1;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        tx_s = 1'b1;
        if (baud_tick) begin
          if (cnt_r == LAST_STOP) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
            done_s  = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
        shift_s = '0;
        tx_s    = 1'b1;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  assign tx      = tx_r;
  assign tx_busy = busy_r;
  assign baud_en = busy_r;
  assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a default 8N1 instance and a 7-data/2-stop instance,
// each fed by a /16 tick generator, compared against a frame model built from the bit rules.
module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int PAR_ODD = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_start, idle_tick;
  logic [7:0] tx_data;
  logic       baud_tick, baud_en, tx, tx_busy, tx_done;
  logic [3:0] tcnt;

  logic       tx_start_b;
  logic [6:0] tx_data_b;
  logic       baud_tick_b, baud_en_b, tx_b, tx_busy_b, tx_done_b;
  logic [3:0] tcnt_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  uart_tx_serializer dut (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .baud_tick(baud_tick), .baud_en(baud_en), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_serializer #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .baud_tick(baud_tick_b), .baud_en(baud_en_b), .tx(tx_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b)
  );

  // Bit-period generators: held at zero while disabled, one tick every 16 clocks otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt <= 4'd0;
    else if (!baud_en) tcnt <= 4'd0;
    else tcnt <= tcnt + 4'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcnt_b <= 4'd0;
    else if (!baud_en_b) tcnt_b <= 4'd0;
    else tcnt_b <= tcnt_b + 4'd1;
  end
  assign baud_tick   = (baud_en && tcnt == 4'd15) || idle_tick;
  assign baud_tick_b = baud_en_b && tcnt_b == 4'd15;

  // Reference frame: bit i of a frame carrying d with nd data bits and ns stop bits.
  function automatic logic exp_bit(input int d, input int nd, input int i);
    if (i == 0) return 1'b0;
    if (i <= nd) return 1'((d >> (i - 1)) & 1);
    if (PAR_EN == 1 && i == nd + 1) return 1'(($countones(d) + PAR_ODD) % 2);
    return 1'b1;
  endfunction

  // Starts a frame on dut at the next edge and checks it bit by bit; ends on the tx_done cycle.
  task automatic send_a(input logic [7:0] d, input bit drop, input string name);
    int n;
    logic e;
    n = 1 + 8 + PAR_EN + 1;
    tx_start = 1'b1;
    tx_data = d;
    idle_tick = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    tx_start = 1'b0;
    idle_tick = 1'b0;
    compared++;
    if (tx !== 1'b0 || tx_busy !== 1'b1 || baud_en !== 1'b1 || tx_done !== 1'b0) begin
      mismatched++;
      $display("FAIL %s accept: tx=%b busy=%b en=%b done=%b, want 0 1 1 0", name, tx, tx_busy, baud_en, tx_done);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      e = exp_bit(int'(d), 8, i);
      compared++;
      if (tx !== e) begin
        mismatched++;
        $display("FAIL %s bit %0d of 0x%02h: tx=%b want %b", name, i, d, tx, e);
      end
      if (i < n - 1) begin
        if (drop && i == 1) begin
          tx_start = 1'b1;
          tx_data = 8'h3C;
          @(negedge clk);
          tx_start = 1'b0;
          repeat (15) @(negedge clk);
        end else begin
          repeat (16) @(negedge clk);
        end
      end
    end
    repeat (7) @(negedge clk);
    compared++;
    if (tx_done !== 1'b0 || tx_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL %s pre-done: done=%b busy=%b, want 0 1", name, tx_done, tx_busy);
    end
    @(negedge clk);
    compared++;
    if (tx_done !== 1'b1 || tx_busy !== 1'b0 || baud_en !== 1'b0 || tx !== 1'b1) begin
      mismatched++;
      $display("FAIL %s done: done=%b busy=%b en=%b tx=%b, want 1 0 0 1", name, tx_done, tx_busy, baud_en, tx);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || baud_en !== 1'b0 || tx_done !== 1'b0 || tx_b !== 1'b1 || tx_busy_b !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_init: tx=%b busy=%b en=%b done=%b tx_b=%b busy_b=%b, want 1 0 0 0 1 0",
               tx, tx_busy, baud_en, tx_done, tx_b, tx_busy_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tx_start = 1'b1;
    tx_data = 8'hA5;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (16 * 4 + 4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    compared++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || baud_en !== 1'b0 || tx_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_midframe: tx=%b busy=%b en=%b done=%b, want 1 0 0 0", tx, tx_busy, baud_en, tx_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_a(8'($urandom_range(0, 255)), 1'b0, "post_reset");
  endtask

  task automatic test_pattern_55;
    @(negedge clk);
    send_a(8'h55, 1'b0, "pattern_55");
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 6)) @(negedge clk);
      send_a(8'($urandom_range(0, 255)), 1'b0, "random");
    end
  endtask

  task automatic test_busy_drop;
    @(negedge clk);
    send_a(8'h81, 1'b1, "busy_drop");
    repeat (20) @(negedge clk);
    compared++;
    if (tx_busy !== 1'b0 || tx !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_drop_idle: busy=%b tx=%b, want 0 1", tx_busy, tx);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    send_a(8'($urandom_range(0, 255)), 1'b0, "b2b_first");
    send_a(8'hF0, 1'b0, "b2b_second");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    @(negedge clk);
    send_a(8'h07, 1'b0, "parity_07");
    @(negedge clk);
    send_a(8'h55, 1'b0, "parity_55");
  endtask
`endif

  task automatic test_stop2;
    int n;
    logic e;
    n = 1 + 7 + PAR_EN + 2;
    @(negedge clk);
    tx_start_b = 1'b1;
    tx_data_b = 7'h7F;
    @(posedge clk); #1;
    tx_start_b = 1'b0;
    compared++;
    if (tx_b !== 1'b0 || tx_busy_b !== 1'b1) begin
      mismatched++;
      $display("FAIL stop2 accept: tx=%b busy=%b, want 0 1", tx_b, tx_busy_b);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      e = exp_bit(32'h7F, 7, i);
      compared++;
      if (tx_b !== e) begin
        mismatched++;
        $display("FAIL stop2 bit %0d: tx=%b want %b", i, tx_b, e);
      end
      if (i < n - 1) repeat (16) @(negedge clk);
    end
    repeat (7) @(negedge clk);
    compared++;
    if (tx_busy_b !== 1'b1 || tx_done_b !== 1'b0) begin
      mismatched++;
      $display("FAIL stop2 pre-done: busy=%b done=%b, want 1 0", tx_busy_b, tx_done_b);
    end
    @(negedge clk);
    compared++;
    if (tx_busy_b !== 1'b0 || tx_done_b !== 1'b1 || tx_b !== 1'b1) begin
      mismatched++;
      $display("FAIL stop2 done: busy=%b done=%b tx=%b, want 0 1 1", tx_busy_b, tx_done_b, tx_b);
    end
  endtask

  initial begin
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    idle_tick  = 1'b0;
    tx_start_b = 1'b0;
    tx_data_b  = 7'h00;
    test_reset();
    test_pattern_55();
    test_random();
    test_busy_drop();
    test_back_to_back();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_stop2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
